rotary_quad_decoder: RTL and testbench

ROTARY_QUAD_DECODER -- requirements
Module: rotary_quad_decoder

---
 rtl/rotary_pkg.sv | 8 +
 rtl/rot_debounce.sv | 34 +++
 rtl/rotary_quad_decoder.sv | 54 +++++
 tb/tb_rotary_quad_decoder.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/rotary_pkg.sv
// rotary_pkg: shared quadrature FSM states and Gray-code sequence constants.
package rotary_pkg;
    typedef enum logic [2:0] {REST, CW1, CW2, CW3, CCW1, CCW2, CCW3} rot_state_t;
    localparam logic [1:0] REST_CODE = 2'b11;
    // {a,b} codes visited from REST, packed MSB-first: 11,01,00,10 and 11,10,00,01
    localparam logic [7:0] CW_SEQ = 8'b11_01_00_10;
    localparam logic [7:0] CCW_SEQ = 8'b11_10_00_01;
endpackage

// File: rtl/rot_debounce.sv
// rot_debounce: 2-flop synchronizer plus optional stability counter for one channel (ROT_DEBOUNCE_EN).
module rot_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic deb
);
    if (DEB_CYCLES < 2 || DEB_CYCLES > 65535) begin : g_range
        $error("DEB_CYCLES out of range 2..65535");
    end
    logic [1:0] sync;
    always_ff @(posedge clk)
        sync <= !rst_n ? 2'b11 : {sync[0], raw};
`ifdef ROT_DEBOUNCE_EN
    logic [15:0] cnt;
    // any return to the stable level restarts the count
    always_ff @(posedge clk)
        if (!rst_n) begin
            cnt <= '0;
            deb <= 1'b1;
        end else if (sync[1] == deb) begin
            cnt <= '0;
        end else if (cnt == 16'(DEB_CYCLES - 1)) begin
            cnt <= '0;
            deb <= sync[1];
        end else begin
            cnt <= cnt + 16'd1;
        end
`else
    assign deb = sync[1];
`endif
endmodule

// File: rtl/rotary_quad_decoder.sv
// rotary_quad_decoder: rotary encoder quadrature decoder with cw/ccw/err pulses.
// Debounce counters are compiled in only when ROT_DEBOUNCE_EN is defined.
module rotary_quad_decoder
    import rotary_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rot_a,
    input  logic rot_b,
    output logic cw,
    output logic ccw,
    output logic err
);
    logic a, b, two, cw_n, ccw_n;
    logic [1:0] ab, ab_q;
    rot_state_t state, nxt;
    rot_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (.clk, .rst_n, .raw(rot_a), .deb(a));
    rot_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (.clk, .rst_n, .raw(rot_b), .deb(b));
    assign ab = {a, b};
    assign two = (ab ^ ab_q) == 2'b11;
    // single-bit steps move forward or back one state; anything else holds
    always_comb begin
        nxt = state;
        if (!two)
            case (state)
                REST: nxt = ab == CW_SEQ[5:4] ? CW1 : ab == CCW_SEQ[5:4] ? CCW1 : REST;
                CW1:  nxt = ab == CW_SEQ[3:2] ? CW2 : ab == REST_CODE ? REST : CW1;
                CW2:  nxt = ab == CW_SEQ[1:0] ? CW3 : ab == CW_SEQ[5:4] ? CW1 : CW2;
                CW3:  nxt = ab == REST_CODE ? REST : ab == CW_SEQ[3:2] ? CW2 : CW3;
                CCW1: nxt = ab == CCW_SEQ[3:2] ? CCW2 : ab == REST_CODE ? REST : CCW1;
                CCW2: nxt = ab == CCW_SEQ[1:0] ? CCW3 : ab == CCW_SEQ[5:4] ? CCW1 : CCW2;
                CCW3: nxt = ab == REST_CODE ? REST : ab == CCW_SEQ[3:2] ? CCW2 : CCW3;
                default: nxt = REST;
            endcase
        cw_n = state == CW3 && nxt == REST;
        ccw_n = state == CCW3 && nxt == REST;
    end
    always_ff @(posedge clk)
        if (!rst_n) begin
            state <= REST;
            ab_q <= REST_CODE;
            cw <= 1'b0;
            ccw <= 1'b0;
            err <= 1'b0;
        end else begin
            state <= nxt;
            ab_q <= ab;
            cw <= cw_n;
            ccw <= ccw_n;
            err <= two;
        end
endmodule

// File: tb/tb_rotary_quad_decoder.sv
// tb_rotary_quad_decoder: directed self-checking bench for rotary_quad_decoder (DEB_CYCLES=4).
module tb_rotary_quad_decoder;
    import rotary_pkg::*;
    localparam int DEB = 4;
`ifdef ROT_DEBOUNCE_EN
    localparam int L = DEB + 3;
    localparam int H = DEB + 3;
`else
    localparam int L = 3;
    localparam int H = 5;
`endif
    logic clk = 1'b0;
    logic rst_n, rot_a, rot_b;
    logic cw, ccw, err;
    int cyc = 0, chg = 0;
    int n_cw, n_ccw, n_err, n_both, lat_bad, last_lat;
    int total = 0, fails = 0;
    logic bad;

    rotary_quad_decoder #(.DEB_CYCLES(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .rot_a(rot_a), .rot_b(rot_b),
        .cw(cw), .ccw(ccw), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cw) begin
            n_cw++;
            last_lat = cyc - chg;
            if (last_lat != L) lat_bad++;
        end
        if (ccw) begin
            n_ccw++;
            last_lat = cyc - chg;
            if (last_lat != L) lat_bad++;
        end
        if (err) n_err++;
        if (cw && ccw) n_both++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear();
        n_cw = 0; n_ccw = 0; n_err = 0; n_both = 0; lat_bad = 0; last_lat = -1;
    endtask

    task automatic drive(input logic a, input logic b, input int n);
        rot_a = a;
        rot_b = b;
        chg = cyc;
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        clear();
        rst_n = 1'b0; rot_a = 1'b1; rot_b = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_cw", int'(cw), 0);
        chk("reset_ccw", int'(ccw), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_state", int'(dut.state), int'(REST));
        rst_n = 1'b1;
        drive(1, 1, 10);
        clear();

        drive(0, 1, 20); drive(0, 0, 20); drive(1, 0, 20); drive(1, 1, 20);
        chk("cw_count", n_cw, 1);
        chk("cw_ccw_count", n_ccw, 0);
        chk("cw_err_count", n_err, 0);
        chk("cw_latency", last_lat, L);
        chk("cw_state", int'(dut.state), int'(REST));
        clear();

        drive(1, 0, 20); drive(0, 0, 20); drive(0, 1, 20); drive(1, 1, 20);
        chk("ccw_count", n_ccw, 1);
        chk("ccw_cw_count", n_cw, 0);
        chk("ccw_latency", last_lat, L);
        chk("ccw_state", int'(dut.state), int'(REST));
        clear();

        drive(0, 1, 20);
        chk("back_mid_state", int'(dut.state), int'(CW1));
        drive(1, 1, 20);
        chk("back_state", int'(dut.state), int'(REST));
        chk("back_pulses", n_cw + n_ccw + n_err, 0);
`ifdef ROT_DEBOUNCE_EN
        bad = 1'b0;
        rot_a = 1'b0;
        repeat (3) begin
            @(negedge clk);
            bad |= dut.state != REST;
        end
        rot_a = 1'b1;
        repeat (20) begin
            @(negedge clk);
            bad |= dut.state != REST;
        end
        #1;
        chk("glitch_state_moved", int'(bad), 0);
        chk("glitch_pulses", n_cw + n_ccw + n_err, 0);
`endif
        clear();

        drive(0, 0, 20);
        chk("err_count", n_err, 1);
        chk("err_state", int'(dut.state), int'(REST));
        chk("err_no_turn", n_cw + n_ccw, 0);
        drive(1, 1, 20);
        chk("err_back_count", n_err, 2);
        chk("err_back_state", int'(dut.state), int'(REST));
        clear();

        drive(0, 1, 20); drive(0, 0, 20); drive(1, 0, 20);
        chk("rst_pre_state", int'(dut.state), int'(CW3));
        rst_n = 1'b0; rot_a = 1'b1; rot_b = 1'b1;
        @(negedge clk);
        chk("rst_mid_outs", int'({cw, ccw, err}), 0);
        chk("rst_mid_state", int'(dut.state), int'(REST));
        #1;
        rst_n = 1'b1;
        drive(1, 1, 20);
        chk("rst_after_pulses", n_cw + n_ccw + n_err, 0);
        chk("rst_after_outs", int'({cw, ccw, err}), 0);
        clear();

        for (int i = 0; i < 10; i++) begin
            drive(0, 1, H); drive(0, 0, H); drive(1, 0, H); drive(1, 1, H);
        end
        drive(1, 1, 20);
        chk("spin_cw_count", n_cw, 10);
        chk("spin_ccw_count", n_ccw, 0);
        chk("spin_err_count", n_err, 0);
        chk("spin_latency_bad", lat_bad, 0);
        chk("never_both", n_both, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
